// File: rtl/mux3_bus_arbiter.sv
// Round-robin arbiter for three requesters sharing one 32-bit path through a 3:1 mux.
// Drives the mux select directly (11 = idle); grants are held until done, request drop, or hold limit.
module mux3_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [1:0]       SEL_IDLE = 2'b11;
  localparam logic [CNT_W-1:0] LIMIT    = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             timeout_q, timeout_d;
  logic             force_rel;
  logic             release_grant;
  logic [2:0]       arb_mask;
  logic [2:0]       pick;

  // Returns {valid, index}; scans from last+1 with wrap so 'last' has lowest priority.
  function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int off = 3; off >= 1; off--) begin
      idx = 2'((int'(last) + off) % 3);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      last_q    <= 2'd2;
      cnt_q     <= '0;
      gnt_q     <= 3'b000;
      sel_q     <= SEL_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    force_rel     = 1'b0;
    release_grant = 1'b0;
    arb_mask      = req;
    pick          = 3'b000;
    case (state_q)
      IDLE: begin
        pick = rr_pick(req, last_q);
        if (pick[2]) begin
          state_d = GRANT;
          owner_d = pick[1:0];
          cnt_d   = '0;
        end
      end
      default: begin
        if (done) begin
          release_grant = 1'b1;
        end else if (!req[owner_q]) begin
          release_grant = 1'b1;
        end else if ((MAX_HOLD != 0) && (cnt_q == LIMIT)) begin
          release_grant = 1'b1;
          force_rel     = 1'b1;
          // A timed-out owner may not win the arbitration its own release triggers.
          arb_mask[owner_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (release_grant) begin
          last_d = owner_q;
          cnt_d  = '0;
          pick   = rr_pick(arb_mask, owner_q);
          if (pick[2]) begin
            owner_d = pick[1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    gnt_d     = 3'b000;
    sel_d     = SEL_IDLE;
    timeout_d = force_rel;
    if (state_d == GRANT) begin
      gnt_d = 3'b001 << owner_d;
      sel_d = owner_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// Directed bench for mux3_bus_arbiter with a 4-cycle hold limit; expected outputs are
// queued when each step is driven and popped when the outputs are sampled.
module tb_mux3_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [2:0] gnt;
    logic       tmo;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  mux3_bus_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    case (g)
      3'b001:  return 2'b00;
      3'b010:  return 2'b01;
      3'b100:  return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic check_out();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (gnt === e.gnt) else begin
      miscompares++;
      $error("FAIL %s gnt: got %b want %b", t, gnt, e.gnt);
    end
    vectors++;
    assert (sel === sel_of(e.gnt)) else begin
      miscompares++;
      $error("FAIL %s sel: got %b want %b", t, sel, sel_of(e.gnt));
    end
    vectors++;
    assert (busy === (|e.gnt)) else begin
      miscompares++;
      $error("FAIL %s busy: got %b want %b", t, busy, |e.gnt);
    end
    vectors++;
    assert (timeout === e.tmo) else begin
      miscompares++;
      $error("FAIL %s timeout: got %b want %b", t, timeout, e.tmo);
    end
    $display("step %-10s req=%b done=%b -> gnt=%b sel=%b busy=%b timeout=%b",
             t, req, done, gnt, sel, busy, timeout);
  endtask

  // Drive inputs, queue the expectation, then sample 1 ns after the next rising edge.
  task automatic step(input logic [2:0] r, input logic d, input logic [2:0] eg,
                      input logic et, input string tag);
    exp_t e;
    req = r;
    done = d;
    e.gnt = eg;
    e.tmo = et;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_now(input logic [2:0] eg, input logic et, input string tag);
    exp_t e;
    e.gnt = eg;
    e.tmo = et;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    check_out();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    done  = 1'b0;
    #12;
    check_now(3'b000, 1'b0, "reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single grant then done with request dropped; done in IDLE is ignored.
    step(3'b001, 1'b0, 3'b001, 1'b0, "g0");
    step(3'b000, 1'b1, 3'b000, 1'b0, "done0");
    step(3'b000, 1'b1, 3'b000, 1'b0, "idledone");

    // Rotation with all requesting, done every 3rd cycle (last owner is 0).
    step(3'b111, 1'b0, 3'b010, 1'b0, "rot1a");
    step(3'b111, 1'b0, 3'b010, 1'b0, "rot1b");
    step(3'b111, 1'b0, 3'b010, 1'b0, "rot1c");
    step(3'b111, 1'b1, 3'b100, 1'b0, "rot2a");
    step(3'b111, 1'b0, 3'b100, 1'b0, "rot2b");
    step(3'b111, 1'b0, 3'b100, 1'b0, "rot2c");
    step(3'b111, 1'b1, 3'b001, 1'b0, "rot0a");
    step(3'b111, 1'b0, 3'b001, 1'b0, "rot0b");
    step(3'b111, 1'b0, 3'b001, 1'b0, "rot0c");
    step(3'b111, 1'b1, 3'b010, 1'b0, "rot1d");

    // done coincides with the hold limit: normal release, no timeout.
    step(3'b111, 1'b0, 3'b010, 1'b0, "lim1");
    step(3'b111, 1'b0, 3'b010, 1'b0, "lim2");
    step(3'b111, 1'b0, 3'b010, 1'b0, "lim3");
    step(3'b111, 1'b1, 3'b100, 1'b0, "limdone");
    step(3'b000, 1'b0, 3'b000, 1'b0, "drop2");

    // Timeout with another requester pending.
    step(3'b011, 1'b0, 3'b001, 1'b0, "to_a1");
    step(3'b011, 1'b0, 3'b001, 1'b0, "to_a2");
    step(3'b011, 1'b0, 3'b001, 1'b0, "to_a3");
    step(3'b011, 1'b0, 3'b001, 1'b0, "to_a4");
    step(3'b011, 1'b0, 3'b010, 1'b1, "to_a5");
    step(3'b011, 1'b0, 3'b010, 1'b0, "to_a6");
    step(3'b000, 1'b0, 3'b000, 1'b0, "drop1");

    // Timeout as sole requester: one idle cycle, then re-grant.
    step(3'b001, 1'b0, 3'b001, 1'b0, "to_b1");
    step(3'b001, 1'b0, 3'b001, 1'b0, "to_b2");
    step(3'b001, 1'b0, 3'b001, 1'b0, "to_b3");
    step(3'b001, 1'b0, 3'b001, 1'b0, "to_b4");
    step(3'b001, 1'b0, 3'b000, 1'b1, "to_b5");
    step(3'b001, 1'b0, 3'b001, 1'b0, "to_b6");
    step(3'b000, 1'b0, 3'b000, 1'b0, "drop0");

    // Owner 1 drops its request; no preemption by new requests before that.
    step(3'b010, 1'b0, 3'b010, 1'b0, "ab1");
    step(3'b111, 1'b0, 3'b010, 1'b0, "nopreempt");
    step(3'b101, 1'b0, 3'b100, 1'b0, "abort");
    step(3'b000, 1'b0, 3'b000, 1'b0, "drop2b");

    // Asynchronous reset mid-grant, then restart with req=110.
    step(3'b001, 1'b0, 3'b001, 1'b0, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_now(3'b000, 1'b0, "async_rst");
    step(3'b001, 1'b0, 3'b000, 1'b0, "rst_held");
    #2;
    rst_n = 1'b1;
    step(3'b110, 1'b0, 3'b010, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
